// File: rtl/ext_pkg.sv
// Shared opcode definitions for the ext_pipe extension unit.
// Imported by the interface, the stage and the top.
package ext_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_SIGN  = 3'd0;
    localparam logic [EXT_OP_W-1:0] EXT_ZERO  = 3'd1;
    localparam logic [EXT_OP_W-1:0] EXT_UPPER = 3'd2;
    localparam logic [EXT_OP_W-1:0] EXT_SBYTE = 3'd3;
    localparam logic [EXT_OP_W-1:0] EXT_ZBYTE = 3'd4;
    localparam logic [EXT_OP_W-1:0] EXT_SHALF = 3'd5;
    localparam logic [EXT_OP_W-1:0] EXT_ZHALF = 3'd6;
    localparam logic [EXT_OP_W-1:0] EXT_WORD  = 3'd7;

endpackage

// File: rtl/ext_pipe_if.sv
// Input/output handshake bundle of ext_pipe.
// master drives beats and out_ready; slave is the extension unit.
interface ext_pipe_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    import ext_pkg::*;

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic                in_valid;
    logic                in_ready;
    logic [EXT_OP_W-1:0] ext_op;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   word;
    logic [OFF_W-1:0]    byte_off;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_err;

    modport master (
        output in_valid, ext_op, imm, word, byte_off, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, ext_op, imm, word, byte_off, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/ext_pipe_stage.sv
// One elastic valid/ready register stage carrying data and error flag.
// The error bit is stored only when EXT_ALIGN_CHK_EN is defined.
module ext_pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         up_err,
    output logic         up_ready,
    output logic         dn_valid,
    output logic [W-1:0] dn_data,
    output logic         dn_err,
    input  logic         dn_ready
);
    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;
    logic         ld;

    assign up_ready = !v_q || dn_ready;
    assign ld       = up_ready && up_valid;
    assign v_d      = up_ready ? up_valid : v_q;
    assign d_d      = ld ? up_data : d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign dn_valid = v_q;
    assign dn_data  = d_q;

`ifdef EXT_ALIGN_CHK_EN
    logic e_q, e_d;

    assign e_d = ld ? up_err : e_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= 1'b0;
        else        e_q <= e_d;
    end

    assign dn_err = e_q;
`else
    logic unused_err;

    assign unused_err = up_err;
    assign dn_err     = 1'b0;
`endif

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate/load-data extension unit (STAGES elastic stages).
// EXT_ALIGN_CHK_EN adds a misaligned-halfword error flag per beat.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int STAGES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    ext_pipe_if.slave   bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int PAD   = DATA_W - IMM_W;

    if (STAGES < 1 || STAGES > 4 || (DATA_W % 16) != 0 || DATA_W <= IMM_W)
    begin : g_bad_cfg
        $error("ext_pipe: illegal STAGES/DATA_W/IMM_W");
    end

    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic [OFF_W-1:0]  hoff;
    logic [DATA_W-1:0] res;
    logic              err_c;

    // Halfword data always comes from the even byte offset.
    assign hoff = bus.byte_off & ~(OFF_W'(1));
    assign bsel = bus.word[8*int'(bus.byte_off) +: 8];
    assign hsel = bus.word[8*int'(hoff) +: 16];

    always_comb begin
        res = '0;
        unique case (bus.ext_op)
            EXT_SIGN:  res = {{PAD{bus.imm[IMM_W-1]}}, bus.imm};
            EXT_ZERO:  res = {{PAD{1'b0}}, bus.imm};
            EXT_UPPER: res = {bus.imm, {PAD{1'b0}}};
            EXT_SBYTE: res = {{(DATA_W-8){bsel[7]}}, bsel};
            EXT_ZBYTE: res = {{(DATA_W-8){1'b0}}, bsel};
            EXT_SHALF: res = {{(DATA_W-16){hsel[15]}}, hsel};
            EXT_ZHALF: res = {{(DATA_W-16){1'b0}}, hsel};
            EXT_WORD:  res = bus.word;
        endcase
    end

`ifdef EXT_ALIGN_CHK_EN
    assign err_c = (bus.ext_op == EXT_SHALF || bus.ext_op == EXT_ZHALF)
                   && bus.byte_off[0];
`else
    assign err_c = 1'b0;
`endif

    logic              vld [STAGES+1];
    logic [DATA_W-1:0] dat [STAGES+1];
    logic              err [STAGES+1];
    logic              rdy [STAGES+1];

    assign vld[0]      = bus.in_valid;
    assign dat[0]      = res;
    assign err[0]      = err_c;
    assign rdy[STAGES] = bus.out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        ext_pipe_stage #(.W(DATA_W)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[i]),
            .up_data  (dat[i]),
            .up_err   (err[i]),
            .up_ready (rdy[i]),
            .dn_valid (vld[i+1]),
            .dn_data  (dat[i+1]),
            .dn_err   (err[i+1]),
            .dn_ready (rdy[i+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[STAGES];
    assign bus.out_data  = dat[STAGES];
    assign bus.out_err   = err[STAGES];

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: one-stage and three-stage instances.
// Define EXT_ALIGN_CHK_EN to also exercise the alignment error flag.
module tb_ext_pipe;
    import ext_pkg::*;

`ifdef EXT_ALIGN_CHK_EN
    localparam logic ERR_MIS = 1'b1;
`else
    localparam logic ERR_MIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ext_pipe_if #(.DATA_W(32), .IMM_W(16)) b1 ();
    ext_pipe_if #(.DATA_W(32), .IMM_W(16)) b3 ();

    ext_pipe #(.DATA_W(32), .IMM_W(16), .STAGES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    ext_pipe #(.DATA_W(32), .IMM_W(16), .STAGES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one beat into the 1-stage unit and check it one cycle later.
    task automatic run1(input string tag,
                        input logic [2:0] op,
                        input logic [15:0] im,
                        input logic [31:0] w,
                        input logic [1:0] off,
                        input logic [31:0] exp,
                        input logic e_err);
        @(negedge clk);
        b1.in_valid = 1'b1;
        b1.ext_op   = op;
        b1.imm      = im;
        b1.word     = w;
        b1.byte_off = off;
        @(negedge clk);
        b1.in_valid = 1'b0;
        b1.ext_op   = 'x;
        b1.imm      = 'x;
        check({tag, "_v"}, 32'(b1.out_valid), 32'd1);
        check(tag, b1.out_data, exp);
        check({tag, "_err"}, 32'(b1.out_err), 32'(e_err));
    endtask

    logic [2:0]  op4  [10];
    logic [15:0] im4  [10];
    logic [31:0] exp4 [10];
    int  sent;
    int  recv;
    bit  saw_full;

    initial begin
        b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        b1.ext_op = '0; b1.imm = '0; b1.word = '0; b1.byte_off = '0;
        b3.in_valid = 1'b0; b3.out_ready = 1'b1;
        b3.ext_op = '0; b3.imm = '0; b3.word = '0; b3.byte_off = '0;

        for (int i = 0; i < 10; i++) begin
            im4[i] = 16'h8000 ^ 16'(16'h1357 * i);
            op4[i] = i[0] ? EXT_ZERO : EXT_SIGN;
            exp4[i] = i[0] ? {16'h0, im4[i]} : {{16{im4[i][15]}}, im4[i]};
        end

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(b1.out_valid), 32'd0);
        check("rst_data", b1.out_data, 32'd0);
        check("rst_err", 32'(b1.out_err), 32'd0);
        check("rst_ready", 32'(b1.in_ready), 32'd1);
        check("rst_ready3", 32'(b3.in_ready), 32'd1);

        run1("sext", EXT_SIGN, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0);
        run1("zext", EXT_ZERO, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0);
        run1("upper", EXT_UPPER, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0);
        run1("lb3", EXT_SBYTE, 16'h0, 32'h80FF7F01, 2'd3, 32'hFFFFFF80, 1'b0);
        run1("lbu1", EXT_ZBYTE, 16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F, 1'b0);
        run1("lbu2", EXT_ZBYTE, 16'h0, 32'h80FF7F01, 2'd2, 32'h000000FF, 1'b0);
        run1("lh2", EXT_SHALF, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF, 1'b0);
        run1("lhu0", EXT_ZHALF, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01, 1'b0);
        run1("lw", EXT_WORD, 16'h0, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF, 1'b0);
        run1("lb0", EXT_SBYTE, 16'h0, 32'h80FF7F01, 2'd0, 32'h00000001, 1'b0);
        run1("mis_h", EXT_SHALF, 16'h0, 32'h12345678, 2'd1, 32'h00005678, ERR_MIS);
        run1("mis_next", EXT_SIGN, 16'h0012, 32'h0, 2'd0, 32'h00000012, 1'b0);
        run1("mis_hu", EXT_ZHALF, 16'h0, 32'h8765F321, 2'd3, 32'h00008765, ERR_MIS);

        // Three stages: 10 back-to-back beats, consumer stalls on cycles 4-6.
        sent = 0;
        recv = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            @(negedge clk);
            b3.out_ready = !(c >= 4 && c <= 6);
            b3.in_valid  = (sent < 10);
            if (sent < 10) begin
                b3.ext_op = op4[sent];
                b3.imm    = im4[sent];
            end
            #1;
            if (b3.in_valid && !b3.in_ready) saw_full = 1'b1;
            if (b3.out_valid) begin
                if (recv < 10)
                    check($sformatf("t4_d%0d", recv), b3.out_data, exp4[recv]);
                else
                    check("t4_dup", 32'(b3.out_valid), 32'd0);
                if (b3.out_ready) recv++;
            end
            if (b3.in_valid && b3.in_ready) sent++;
        end
        b3.in_valid  = 1'b0;
        b3.out_ready = 1'b1;
        check("t4_sent", 32'(sent), 32'd10);
        check("t4_recv", 32'(recv), 32'd10);
        check("t4_full", 32'(saw_full), 32'd1);
        repeat (4) @(negedge clk);
        check("t4_empty", 32'(b3.out_valid), 32'd0);

        // Reset with beats in flight.
        b3.out_ready = 1'b0;
        b3.in_valid  = 1'b1;
        b3.ext_op    = EXT_SIGN;
        b3.imm       = 16'hAAAA;
        @(negedge clk);
        b3.imm = 16'hBBBB;
        @(negedge clk);
        b3.in_valid = 1'b0;
        @(negedge clk);
        check("t5_pre", 32'(b3.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(b3.out_valid), 32'd0);
        check("t5_data", b3.out_data, 32'd0);
        check("t5_ready", 32'(b3.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        b3.out_ready = 1'b1;
        @(negedge clk);
        b3.in_valid = 1'b1;
        b3.ext_op   = EXT_UPPER;
        b3.imm      = 16'h1234;
        @(negedge clk);
        b3.in_valid = 1'b0;
        check("t5_lat1", 32'(b3.out_valid), 32'd0);
        @(negedge clk);
        check("t5_lat2", 32'(b3.out_valid), 32'd0);
        @(negedge clk);
        check("t5_lat3", 32'(b3.out_valid), 32'd1);
        check("t5_out", b3.out_data, 32'h12340000);
        @(negedge clk);
        check("t5_drain", 32'(b3.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
